// File: rtl/jtcps1_sdram_pkg.sv
// Shared types and constants for the CPS SDRAM request scheduler.
package jtcps1_sdram_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   localparam logic [1:0] BA_RAM = 2'd0;
   localparam logic [1:0] BA_SND = 2'd1;
   localparam logic [1:0] BA_GFX = 2'd2;
   localparam logic [1:0] BA_ROM = 2'd3;

   localparam logic [9:0] RFSH_PERIOD_DFLT = 10'd384;

endpackage

// File: rtl/jtcps1_sdram_arb_if.sv
// Single-access command port between the scheduler and the SDRAM engine.
interface jtcps1_sdram_arb_if #(
   parameter int AW = 22
);

   logic [AW-1:0] sd_addr;
   logic [1:0]    sd_ba;
   logic          sd_rd;
   logic          sd_wr;
   logic          sd_rfsh;
   logic [15:0]   sd_din;
   logic [1:0]    sd_din_m;
   logic          sd_ack;
   logic          sd_rdy;

   modport master (
      output sd_addr, sd_ba, sd_rd, sd_wr, sd_rfsh,
      output sd_din, sd_din_m,
      input  sd_ack, sd_rdy
   );

   modport slave (
      input  sd_addr, sd_ba, sd_rd, sd_wr, sd_rfsh,
      input  sd_din, sd_din_m,
      output sd_ack, sd_rdy
   );

endinterface

// File: rtl/jtcps1_arb_pick.sv
// Winner select: refresh, then lowest starved bank, then ba0>ba3>ba2>ba1.
module jtcps1_arb_pick
   import jtcps1_sdram_pkg::*;
(
   input  logic [3:0] req,
   input  logic [3:0] starve,
   input  logic       rfsh_pend,
   output logic [1:0] idx,
   output logic       rfsh,
   output logic       valid
);

   logic [3:0] hit;

   assign hit = req & starve;

   always_comb begin
      idx   = BA_RAM;
      rfsh  = 1'b0;
      valid = 1'b1;
      if (rfsh_pend)    rfsh = 1'b1;
      else if (hit[0])  idx  = BA_RAM;
      else if (hit[1])  idx  = BA_SND;
      else if (hit[2])  idx  = BA_GFX;
      else if (hit[3])  idx  = BA_ROM;
      else if (req[0])  idx  = BA_RAM;
      else if (req[3])  idx  = BA_ROM;
      else if (req[2])  idx  = BA_GFX;
      else if (req[1])  idx  = BA_SND;
      else              valid = 1'b0;
   end

endmodule

// File: rtl/jtcps1_sdram_arb.sv
// Four-bank SDRAM request scheduler with starvation override and
// blanking-time auto-refresh pacing.
module jtcps1_sdram_arb
   import jtcps1_sdram_pkg::*;
#(
   parameter int         AW          = 22,
   parameter logic [5:0] STARVE      = 6'd31,
   parameter logic [9:0] RFSH_PERIOD = RFSH_PERIOD_DFLT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          refresh_en,
   input  logic [AW-1:0] ba0_addr,
   input  logic          ba0_rd,
   input  logic          ba0_wr,
   input  logic [15:0]   ba0_din,
   input  logic [1:0]    ba0_din_m,
   output logic          ba0_ack,
   output logic          ba0_rdy,
   input  logic [AW-1:0] ba1_addr,
   input  logic          ba1_rd,
   output logic          ba1_ack,
   output logic          ba1_rdy,
   input  logic [AW-1:0] ba2_addr,
   input  logic          ba2_rd,
   output logic          ba2_ack,
   output logic          ba2_rdy,
   input  logic [AW-1:0] ba3_addr,
   input  logic          ba3_rd,
   output logic          ba3_ack,
   output logic          ba3_rdy,
   jtcps1_sdram_arb_if.master sd
);

   state_t        state, nxt;
   logic [3:0]    req, own, req_m, starve;
   logic [5:0]    wcnt [4];
   logic [9:0]    rcnt;
   logic          rfsh_pend;
   logic [1:0]    pick_idx;
   logic          pick_rf, pick_v, take;
   logic [AW-1:0] pick_addr;
   logic [1:0]    gnt;
   logic          rf_q, wr_q;
   logic [AW-1:0] addr_q;
   logic [15:0]   din_q;
   logic [1:0]    dm_q;
   logic          ack_v, rdy_v;
   logic [3:0]    ack_vec, rdy_vec;

   // The granted bank is deaf from grant until its transaction ends
   assign req   = {ba3_rd, ba2_rd, ba1_rd, ba0_rd | ba0_wr};
   assign own   = (state != IDLE && !rf_q) ? (4'b0001 << gnt) : 4'd0;
   assign req_m = req & ~own;
   assign take  = state == IDLE && pick_v && !pick_rf;

   always_comb begin
      starve = 4'd0;
      for (int n = 0; n < 4; n++) starve[n] = wcnt[n] >= STARVE;
   end

   jtcps1_arb_pick u_pick (
      .req       (req_m),
      .starve    (starve),
      .rfsh_pend (rfsh_pend),
      .idx       (pick_idx),
      .rfsh      (pick_rf),
      .valid     (pick_v)
   );

   always_comb begin
      unique case (pick_idx)
         BA_SND:  pick_addr = ba1_addr;
         BA_GFX:  pick_addr = ba2_addr;
         BA_ROM:  pick_addr = ba3_addr;
         default: pick_addr = ba0_addr;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:    if (pick_v) nxt = ISSUE;
         ISSUE:   if (sd.sd_ack) nxt = sd.sd_rdy ? IDLE : WAIT;
         WAIT:    if (sd.sd_rdy) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      ack_v = state == ISSUE && sd.sd_ack && !rf_q;
      rdy_v = (state == WAIT || (state == ISSUE && sd.sd_ack))
              && sd.sd_rdy && !rf_q;
      ack_vec = ack_v ? (4'b0001 << gnt) : 4'd0;
      rdy_vec = rdy_v ? (4'b0001 << gnt) : 4'd0;
      sd.sd_rd   = state == ISSUE && !rf_q && !wr_q;
      sd.sd_wr   = state == ISSUE && wr_q;
      sd.sd_rfsh = state == ISSUE && rf_q;
   end

   assign {ba3_ack, ba2_ack, ba1_ack, ba0_ack} = ack_vec;
   assign {ba3_rdy, ba2_rdy, ba1_rdy, ba0_rdy} = rdy_vec;
   assign sd.sd_addr  = addr_q;
   assign sd.sd_ba    = gnt;
   assign sd.sd_din   = din_q;
   assign sd.sd_din_m = dm_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         gnt    <= BA_RAM;
         rf_q   <= 1'b0;
         wr_q   <= 1'b0;
         addr_q <= '0;
         din_q  <= 16'd0;
         dm_q   <= 2'b11;
      end else if (state == IDLE && pick_v) begin
         rf_q   <= pick_rf;
         gnt    <= pick_rf ? BA_RAM : pick_idx;
         wr_q   <= !pick_rf && pick_idx == BA_RAM && ba0_wr;
         addr_q <= pick_rf ? '0 : pick_addr;
         din_q  <= (!pick_rf && pick_idx == BA_RAM) ? ba0_din : 16'd0;
         dm_q   <= (!pick_rf && pick_idx == BA_RAM) ? ba0_din_m : 2'b11;
      end
   end

   always_ff @(posedge clk) begin
      for (int n = 0; n < 4; n++) begin
         if (rst || !req_m[n] || (take && pick_idx == 2'(n)))
            wcnt[n] <= 6'd0;
         else if (wcnt[n] != 6'd63)
            wcnt[n] <= wcnt[n] + 6'd1;
      end
   end

   // Leaving blanking drops a refresh that has not been issued yet
   always_ff @(posedge clk) begin
      if (rst || !refresh_en) begin
         rcnt      <= 10'd0;
         rfsh_pend <= 1'b0;
      end else if (rcnt == RFSH_PERIOD - 10'd1) begin
         rcnt      <= 10'd0;
         rfsh_pend <= 1'b1;
      end else begin
         rcnt <= rcnt + 10'd1;
         if (state == ISSUE && rf_q && sd.sd_ack) rfsh_pend <= 1'b0;
      end
   end

endmodule

// File: tb/tb_jtcps1_sdram_arb.sv
// Directed bench for jtcps1_sdram_arb with a simple fixed-latency engine.
module tb_jtcps1_sdram_arb;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        refresh_en = 1'b0;
   logic [21:0] a0, a1, a2, a3;
   logic [3:0]  rd;
   logic        wr0;
   logic [15:0] din0;
   logic [1:0]  dm0;
   logic [3:0]  ack, rdy;

   jtcps1_sdram_arb_if sd ();

   jtcps1_sdram_arb dut (
      .clk        (clk),
      .rst        (rst),
      .refresh_en (refresh_en),
      .ba0_addr   (a0),
      .ba0_rd     (rd[0]),
      .ba0_wr     (wr0),
      .ba0_din    (din0),
      .ba0_din_m  (dm0),
      .ba0_ack    (ack[0]),
      .ba0_rdy    (rdy[0]),
      .ba1_addr   (a1),
      .ba1_rd     (rd[1]),
      .ba1_ack    (ack[1]),
      .ba1_rdy    (rdy[1]),
      .ba2_addr   (a2),
      .ba2_rd     (rd[2]),
      .ba2_ack    (ack[2]),
      .ba2_rdy    (rdy[2]),
      .ba3_addr   (a3),
      .ba3_rd     (rd[3]),
      .ba3_ack    (ack[3]),
      .ba3_rdy    (rdy[3]),
      .sd         (sd.master)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         failures = 0;
   int         ack_cnt [4];
   int         rdy_cnt [4];
   int         rfsh_cnt, wr_samples, wr_bad;
   logic [3:0] auto_drop;
   logic [15:0] exp_din;
   logic [1:0] exp_dm;
   logic [3:0] order [$];
   int         ack_d = 2;
   int         rdy_d = 6;
   logic       eng_hold = 1'b0;
   int         ecnt = 0;
   int         lat;

   // engine: ack ack_d cycles after the command shows, rdy rdy_d after ack
   initial begin
      sd.sd_ack = 1'b0;
      sd.sd_rdy = 1'b0;
      forever begin
         @(posedge clk); #1;
         sd.sd_ack = 1'b0;
         sd.sd_rdy = 1'b0;
         if (ecnt == 0) begin
            if (sd.sd_rd || sd.sd_wr || sd.sd_rfsh) ecnt = 1;
         end else if (!eng_hold) begin
            ecnt++;
            if (ecnt == ack_d + 1) sd.sd_ack = 1'b1;
            if (ecnt == ack_d + rdy_d + 1) begin
               sd.sd_rdy = 1'b1;
               ecnt = 0;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      for (int n = 0; n < 4; n++) begin
         if (ack[n]) begin
            ack_cnt[n]++;
            if (auto_drop[n]) begin
               rd[n] = 1'b0;
               if (n == 0) wr0 = 1'b0;
            end
         end
         if (rdy[n]) rdy_cnt[n]++;
      end
      if (sd.sd_ack && (sd.sd_rd || sd.sd_wr || sd.sd_rfsh)) begin
         order.push_back({sd.sd_rfsh, sd.sd_wr, sd.sd_ba});
         if (sd.sd_rfsh) rfsh_cnt++;
      end
      if (sd.sd_wr) begin
         wr_samples++;
         if (sd.sd_din !== exp_din || sd.sd_din_m !== exp_dm) wr_bad++;
      end
      @(posedge clk); #1;
   endtask

   task automatic clr();
      for (int n = 0; n < 4; n++) begin
         ack_cnt[n] = 0;
         rdy_cnt[n] = 0;
      end
      rfsh_cnt = 0;
      wr_samples = 0;
      wr_bad = 0;
      order.delete();
   endtask

   task automatic wait_rdy(input int n, input int budget);
      int k;
      k = 0;
      while (rdy_cnt[n] < 1 && k < budget) begin
         step();
         k++;
      end
      chk("rdy_in_time", 32'(k < budget), 32'd1);
   endtask

   function automatic logic [3:0] ord(input int i);
      return (i < order.size()) ? order[i] : 4'hF;
   endfunction

   initial begin
      rd = 4'd0; wr0 = 1'b0; din0 = 16'd0; dm0 = 2'b00;
      a0 = 22'h000100; a1 = 22'h011111; a2 = 22'h022222;
      a3 = 22'h012345;
      auto_drop = 4'hF; exp_din = 16'hA55A; exp_dm = 2'b01;
      clr();

      // reset state
      step(); step();
      chk("rst_cmd", {29'd0, sd.sd_rd, sd.sd_wr, sd.sd_rfsh}, 0);
      chk("rst_addr", 32'(sd.sd_addr), 0);
      chk("rst_ba", 32'(sd.sd_ba), 0);
      chk("rst_din", 32'(sd.sd_din), 0);
      chk("rst_din_m", 32'(sd.sd_din_m), 32'd3);
      chk("rst_ackrdy", {24'd0, ack, rdy}, 0);
      rst = 1'b0;
      step();

      // single ba3 read
      rd[3] = 1'b1;
      step();
      chk("t1_sd_rd", 32'(sd.sd_rd), 1);
      chk("t1_sd_ba", 32'(sd.sd_ba), 3);
      chk("t1_sd_addr", 32'(sd.sd_addr), 32'h012345);
      wait_rdy(3, 30);
      repeat (3) step();
      chk("t1_ack_cnt", 32'(ack_cnt[3]), 1);
      chk("t1_rdy_cnt", 32'(rdy_cnt[3]), 1);
      chk("t1_order", 32'(ord(0)), 32'h3);

      // ba0 write (rd+wr both high) against ba1/ba2 reads
      clr();
      din0 = 16'hA55A; dm0 = 2'b01;
      rd[0] = 1'b1; wr0 = 1'b1; rd[1] = 1'b1; rd[2] = 1'b1;
      wait_rdy(1, 60);
      repeat (2) step();
      chk("t2_n", 32'(order.size()), 3);
      chk("t2_first", 32'(ord(0)), 32'h4);
      chk("t2_second", 32'(ord(1)), 32'h2);
      chk("t2_third", 32'(ord(2)), 32'h1);
      chk("t2_wr_samples", 32'(wr_samples), 3);
      chk("t2_wr_hold", 32'(wr_bad), 0);

      // starvation of ba1 under continuous ba0 traffic
      clr();
      auto_drop[0] = 1'b0;
      rd[0] = 1'b1;
      repeat (3) step();
      rd[1] = 1'b1;
      lat = 0;
      while (!(sd.sd_rd && sd.sd_ba == 2'd1) && lat < 80) begin
         step();
         lat++;
      end
      chk("t3_lat_min", 32'(lat >= 32), 1);
      chk("t3_lat_max", 32'(lat <= 41), 1);
      chk("t3_ba0_before", 32'(ack_cnt[0] >= 3), 1);
      rd[0] = 1'b0;
      auto_drop[0] = 1'b1;
      wait_rdy(1, 30);
      repeat (15) step();
      chk("t3_ba1_rdy", 32'(rdy_cnt[1]), 1);

      // refresh pacing, no bank traffic
      clr();
      refresh_en = 1'b1;
      repeat (1000) step();
      refresh_en = 1'b0;
      repeat (12) step();
      chk("t4_rfsh_cnt", 32'(rfsh_cnt), 2);
      chk("t4_no_bank", 32'(ack_cnt[0] + ack_cnt[1] + ack_cnt[2]
          + ack_cnt[3] + rdy_cnt[0] + rdy_cnt[1] + rdy_cnt[2]
          + rdy_cnt[3]), 0);
      chk("t4_order", 32'(ord(0)), 32'h8);

      // refresh pending together with ba0 and ba3 behind a stalled ba2
      clr();
      rd[2] = 1'b1;
      step();
      eng_hold = 1'b1;
      refresh_en = 1'b1;
      rd[0] = 1'b1; rd[3] = 1'b1;
      repeat (400) step();
      eng_hold = 1'b0;
      wait_rdy(3, 60);
      refresh_en = 1'b0;
      repeat (2) step();
      chk("t5_n", 32'(order.size()), 4);
      chk("t5_ba2", 32'(ord(0)), 32'h2);
      chk("t5_rfsh", 32'(ord(1)), 32'h8);
      chk("t5_ba0", 32'(ord(2)), 32'h0);
      chk("t5_ba3", 32'(ord(3)), 32'h3);

      // ack and rdy in the same ISSUE cycle
      clr();
      rdy_d = 0;
      rd[1] = 1'b1;
      wait_rdy(1, 20);
      chk("t6_ack", 32'(ack_cnt[1]), 1);
      chk("t6_rdy", 32'(rdy_cnt[1]), 1);
      rdy_d = 6;
      rd[2] = 1'b1;
      step();
      chk("t6_next_cmd", {30'd0, sd.sd_rd, sd.sd_ba == 2'd2}, 32'd3);
      wait_rdy(2, 20);
      repeat (2) step();

      // reset while a ba2 read waits for data
      clr();
      rd[2] = 1'b1;
      lat = 0;
      while (ack_cnt[2] < 1 && lat < 20) begin
         step();
         lat++;
      end
      chk("t7_acked", 32'(ack_cnt[2]), 1);
      step(); step();
      rst = 1'b1;
      step();
      chk("t7_cmd", {29'd0, sd.sd_rd, sd.sd_wr, sd.sd_rfsh}, 0);
      chk("t7_addr", 32'(sd.sd_addr), 0);
      chk("t7_ba", 32'(sd.sd_ba), 0);
      chk("t7_din_m", 32'(sd.sd_din_m), 32'd3);
      rst = 1'b0;
      repeat (10) step();
      chk("t7_no_rdy", 32'(rdy_cnt[2]), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
